// File: rtl/arbitro_roteador.sv
// -----------------------------------------------------------------------------
// arbitro_roteador
// Round-robin arbiter and sequencer for the 4:1 router datapath. Four
// requesters (A, B, C, D) share one registered output channel with a
// valid/ready handshake. A granted requester may stream up to MAX_BEATS words
// before the grant is released and rotates.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   A,B,C,D    in   requester data words (DATA_W each)
//   req        in   request per requester (bit0=A ... bit3=D)
//   ready_in   in   sink accepts Saida this cycle
//   Saida      out  registered output word
//   valid_out  out  Saida holds a valid word
//   SEL        out  router select of the current grant (0=A ... 3=D)
//   grant      out  one-hot grant, zero when idle
//   ack        out  one-cycle pulse to the requester whose word transferred
//
// Build option:
//   ARBITRO_PRIO_FIXA_EN  fixed priority A>B>C>D instead of round-robin.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// OCIOSO    | no grant; waiting for any request
// TRANSMITE | grant held; Saida valid, waiting for transfers / release
// -----------------------------------------------------------------------------
module arbitro_roteador #(
    parameter int DATA_W    = 4,
    parameter int SEL_BITS  = 2,
    parameter int MAX_BEATS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [DATA_W-1:0]   C,
    input  logic [DATA_W-1:0]   D,
    input  logic [3:0]          req,
    input  logic                ready_in,
    output logic [DATA_W-1:0]   Saida,
    output logic                valid_out,
    output logic [SEL_BITS-1:0] SEL,
    output logic [3:0]          grant,
    output logic [3:0]          ack
);

    typedef enum logic {
        OCIOSO    = 1'b0,
        TRANSMITE = 1'b1
    } estado_t;

    localparam logic [3:0] ULTIMO_BEAT = 4'(MAX_BEATS - 1);

    estado_t             estado_q, estado_d;
    logic [DATA_W-1:0]   saida_q, saida_d;
    logic                valid_q, valid_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [3:0]          grant_q, grant_d;
    logic [SEL_BITS-1:0] ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;

    logic                transfer;
    logic [SEL_BITS-1:0] vencedor;
    logic [DATA_W-1:0]   dado_venc;
    logic [DATA_W-1:0]   dado_sel;

    function automatic logic [DATA_W-1:0] mux4(
        input logic [SEL_BITS-1:0] s,
        input logic [DATA_W-1:0]   a,
        input logic [DATA_W-1:0]   b,
        input logic [DATA_W-1:0]   c,
        input logic [DATA_W-1:0]   d
    );
        case (s)
            2'd0:    mux4 = a;
            2'd1:    mux4 = b;
            2'd2:    mux4 = c;
            default: mux4 = d;
        endcase
    endfunction

    // Scan base, base+1, ... (mod 4); scanning downwards and overwriting
    // leaves the requester closest to the base as the winner.
    function automatic logic [SEL_BITS-1:0] escolhe(
        input logic [3:0]          r,
        input logic [SEL_BITS-1:0] base
    );
        logic [SEL_BITS-1:0] idx;
        escolhe = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + SEL_BITS'(i);
            if (r[idx]) escolhe = idx;
        end
    endfunction

    // With fixed priority the pointer is pinned at 0, so the same scan
    // degenerates to lowest-index-wins.
    assign vencedor  = escolhe(req, ptr_q);
    assign dado_venc = mux4(vencedor, A, B, C, D);
    assign dado_sel  = mux4(sel_q, A, B, C, D);
    assign transfer  = valid_q & ready_in;

    always_comb begin
        estado_d = estado_q;
        saida_d  = saida_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;

        case (estado_q)
            OCIOSO: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                if (|req) begin
                    sel_d    = vencedor;
                    grant_d  = 4'b0001 << vencedor;
                    saida_d  = dado_venc;
                    valid_d  = 1'b1;
                    cnt_d    = 4'd0;
                    estado_d = TRANSMITE;
                end
            end
            TRANSMITE: begin
                // Requests are only looked at when a word actually leaves.
                if (transfer) begin
                    if ((cnt_q == ULTIMO_BEAT) || !req[sel_q]) begin
`ifdef ARBITRO_PRIO_FIXA_EN
                        ptr_d = '0;
`else
                        ptr_d = sel_q + SEL_BITS'(1);
`endif
                        valid_d  = 1'b0;
                        grant_d  = 4'b0000;
                        cnt_d    = 4'd0;
                        estado_d = OCIOSO;
                    end else begin
                        saida_d = dado_sel;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                estado_d = OCIOSO;
                valid_d  = 1'b0;
                grant_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            saida_q  <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            grant_q  <= 4'b0000;
            ptr_q    <= '0;
            cnt_q    <= 4'd0;
        end else begin
            estado_q <= estado_d;
            saida_q  <= saida_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Saida     = saida_q;
    assign valid_out = valid_q;
    assign SEL       = sel_q;
    assign grant     = grant_q;
    assign ack       = transfer ? grant_q : 4'b0000;

endmodule

// File: tb/tb_arbitro_roteador.sv
// -----------------------------------------------------------------------------
// tb_arbitro_roteador
// Self-checking bench for arbitro_roteador. A session-level reference model
// (who owns the channel, how many words it has delivered, where the
// round-robin pointer sits) predicts every presented word into a scoreboard
// queue; a monitor on the falling edge compares outputs and pops the
// scoreboard on every handshake. Directed scenarios run first, then random
// traffic with occasional resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arbitro_roteador;

    localparam int DATA_W    = 4;
    localparam int SEL_BITS  = 2;
    localparam int MAX_BEATS = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [DATA_W-1:0]   A, B, C, D;
    logic [3:0]          req;
    logic                ready_in;
    logic [DATA_W-1:0]   Saida;
    logic                valid_out;
    logic [SEL_BITS-1:0] SEL;
    logic [3:0]          grant;
    logic [3:0]          ack;

    always #5 clock = ~clock;

    arbitro_roteador #(
        .DATA_W   (DATA_W),
        .SEL_BITS (SEL_BITS),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .req      (req),
        .ready_in (ready_in),
        .Saida    (Saida),
        .valid_out(valid_out),
        .SEL      (SEL),
        .grant    (grant),
        .ack      (ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int dono;
        int palavra;
    } item_t;

    item_t sb[$];
    item_t it;
    int    m_owner = -1;
    int    m_beats = 0;
    int    m_ptr   = 0;
    int    m_sel   = 0;
    int    m_word  = 0;
    bit    mon_en  = 1'b0;

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef ARBITRO_PRIO_FIXA_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
`endif
        return -1;
    endfunction

    function automatic int dado(input int k);
        case (k)
            0:       return int'(A);
            1:       return int'(B);
            2:       return int'(C);
            default: return int'(D);
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            m_sel   = 0;
            m_word  = 0;
            sb.delete();
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = pick(req, m_ptr);
                m_beats = 0;
                m_sel   = m_owner;
                m_word  = dado(m_owner);
                sb.push_back('{m_owner, m_word});
            end
        end else if (ready_in) begin
            m_beats++;
            if (m_beats == MAX_BEATS || !req[m_owner]) begin
`ifndef ARBITRO_PRIO_FIXA_EN
                m_ptr = (m_owner + 1) % 4;
`endif
                m_owner = -1;
            end else begin
                m_word = dado(m_owner);
                sb.push_back('{m_owner, m_word});
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] exp_g, exp_ack, prev_grant;
    int         ack_cnt[4];
    int         idle_cnt;
    logic [3:0] glog[$];

    always @(negedge clock) begin
        if (mon_en) begin
            exp_g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            exp_ack = (m_owner >= 0 && ready_in) ? exp_g : 4'b0000;
            chk("valid_out", valid_out, m_owner >= 0);
            chk("grant", grant, exp_g);
            chk("SEL", SEL, m_sel);
            chk("Saida", Saida, m_word);
            chk("ack", ack, exp_ack);
            chk("inv_onehot", $countones(grant) <= 1, 1);
            chk("inv_ack_subset", (ack & ~grant) == 4'b0000, 1);
            chk("inv_valid_grant", !valid_out || (grant != 4'b0000), 1);
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    it = sb.pop_front();
                    chk("sb_sel", SEL, it.dono);
                    chk("sb_word", Saida, it.palavra);
                end
            end
            for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
            if (grant != 4'b0000 && prev_grant == 4'b0000) glog.push_back(grant);
            if (!valid_out) idle_cnt++;
            prev_grant = grant;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic limpa();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        idle_cnt = 0;
        glog.delete();
    endtask

    logic [3:0] exp_rr[5];
    logic [3:0] exp_bd[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 4'b0000; ready_in = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        prev_grant = 4'b0000;
        limpa();
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
`ifdef ARBITRO_PRIO_FIXA_EN
        for (int i = 0; i < 4; i++) exp_bd[i] = 4'b0010;
`else
        exp_bd[0] = 4'b0010; exp_bd[1] = 4'b1000; exp_bd[2] = 4'b0010; exp_bd[3] = 4'b1000;
`endif
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t1_valid", valid_out, 0);
            chk("t1_grant", grant, 0);
            chk("t1_saida", Saida, 0);
            chk("t1_sel", SEL, 0);
        end
        step();

        // single requester A, drop req after the first ack
        limpa();
        A = 4'h5; req = 4'b0001; ready_in = 1'b1;
        step();
        @(negedge clock);
        chk("t2_valid", valid_out, 1);
        chk("t2_sel", SEL, 0);
        chk("t2_grant", grant, 4'b0001);
        chk("t2_saida", Saida, 5);
        step();
        req = 4'b0000;
        repeat (4) step();
        chk("t2_acks_A", ack_cnt[0], 2);
        chk("t2_idle", valid_out, 0);

        // all requesting: rotation A,B,C,D,A with bubbles
        do_reset();
        limpa();
        req = 4'b1111; ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
        end
        for (int i = 0; i < 4; i++) chk("t3_acks_each", ack_cnt[i], 4);
        chk("t3_idle_cycles", idle_cnt, 4);
        step();
        step();
        chk("t3_grant_count", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t3_grant_order", (glog.size() > i) ? int'(glog[i]) : 0, exp_rr[i]);
        req = 4'b0000;
        repeat (6) step();

        // grant to B with the sink stalled
        do_reset();
        limpa();
        A = 4'h3; B = 4'h9; req = 4'b0010; ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            A = 4'($urandom);
            req = (i == 1) ? 4'b0011 : 4'b0010;
            @(negedge clock);
            chk("t4_saida", Saida, 9);
            chk("t4_sel", SEL, 1);
            chk("t4_valid", valid_out, 1);
            chk("t4_ack", ack, 0);
        end
        step();
        ready_in = 1'b1; req = 4'b0000;
        @(negedge clock);
        chk("t4_ack_pulse", ack, 4'b0010);
        step();
        step();
        chk("t4_acks_B", ack_cnt[1], 1);
        chk("t4_idle", valid_out, 0);

        // reset in the middle of a C burst; next grant must start from A
        do_reset();
        limpa();
        req = 4'b0010; ready_in = 1'b1;
        step();
        req = 4'b0000;
        step();
        req = 4'b0100; C = 4'hC;
        step();
        step();
        step();
        reset = 1'b1; ready_in = 1'b0;
        step();
        reset = 1'b0; req = 4'b1111; ready_in = 1'b1;
        @(negedge clock);
        chk("t5_valid", valid_out, 0);
        chk("t5_grant", grant, 0);
        chk("t5_sel", SEL, 0);
        chk("t5_saida", Saida, 0);
        chk("t5_ack", ack, 0);
        chk("t5_acks_C", ack_cnt[2], 2);
        step();
        @(negedge clock);
        chk("t5_next_A", grant, 4'b0001);
        step();
        req = 4'b0000;
        repeat (4) step();

        // B and D competing
        do_reset();
        limpa();
        req = 4'b1010; ready_in = 1'b1;
        repeat (22) begin
            step();
            B = 4'($urandom); D = 4'($urandom);
        end
        chk("t6_grant_count", glog.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            chk("t6_grant_order", (glog.size() > i) ? int'(glog[i]) : 0, exp_bd[i]);
        req = 4'b0000;
        repeat (6) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            ready_in = ($urandom_range(0, 3) != 0);
            A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
        end
        step();
        reset = 1'b0; req = 4'b0000; ready_in = 1'b1;
        repeat (10) step();
        chk("end_sb_empty", sb.size(), 0);
        chk("end_idle", valid_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
